alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu.sv | 46 ++++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU and the two-requester ALU arbiter.
// Holds the ALU opcode enum, the arbiter FSM states and the round-robin pick.
package alu_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } control_operation;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Contention goes to the favoured index; a lone requester always wins.
  function automatic logic rr_pick(
    input logic [1:0] valid,
    input logic       prio
  );
    if (valid == 2'b11) begin
      return prio;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: result and zero flag for a 4-bit control_operation.
// Ports: i_op, i_src_a, i_src_b in; o_result, o_zero out. Codes 10-15 give 0.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero
);

  localparam int SHW = $clog2(DATA_WIDTH);

  control_operation      w_op;
  logic [SHW-1:0]        w_shamt;
  logic                  w_lt_s;
  logic                  w_lt_u;

  assign w_op    = control_operation'(i_op);
  assign w_shamt = i_src_b[SHW-1:0];
  assign w_lt_s  = $signed(i_src_a) < $signed(i_src_b);
  assign w_lt_u  = i_src_a < i_src_b;

  always_comb begin
    o_result = '0;
    case (w_op)
      OP_ADD:  o_result = i_src_a + i_src_b;
      OP_SUB:  o_result = i_src_a - i_src_b;
      OP_AND:  o_result = i_src_a & i_src_b;
      OP_OR:   o_result = i_src_a | i_src_b;
      OP_XOR:  o_result = i_src_a ^ i_src_b;
      OP_SLL:  o_result = i_src_a << w_shamt;
      OP_SRL:  o_result = i_src_a >> w_shamt;
      OP_SRA:  o_result = $unsigned($signed(i_src_a) >>> w_shamt);
      OP_SLT:  o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTU: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt_u};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: IDLE -> EXEC -> RESP, round-robin.
// Ports: clk, rst_n; Req{Valid,Ready,Op,SrcA,SrcB}; Rsp{Valid,Ready,Result,
// Zero,Negative}; GrantCount (live only with ALU_ARBITER_STATS_EN defined).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 ReqValid,
  output logic [1:0]                 ReqReady,
  input  logic [1:0][3:0]            ReqOp,
  input  logic [1:0][DATA_WIDTH-1:0] ReqSrcA,
  input  logic [1:0][DATA_WIDTH-1:0] ReqSrcB,
  output logic [1:0]                 RspValid,
  input  logic [1:0]                 RspReady,
  output logic [DATA_WIDTH-1:0]      RspResult,
  output logic                       RspZero,
  output logic                       RspNegative,
  output logic [1:0][15:0]           GrantCount
);

  arb_state_e            r_state;
  logic                  r_owner;
  logic                  r_prio;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_src_a;
  logic [DATA_WIDTH-1:0] r_src_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_neg;

  logic                  w_rsp_done;
  logic                  w_open;
  logic                  w_win;
  logic [1:0]            w_grant;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_zero;

  // Owner consuming its response reopens arbitration in the same cycle.
  assign w_rsp_done = (r_state == ST_RESP) && RspReady[r_owner];
  assign w_open     = (r_state == ST_IDLE) || w_rsp_done;
  assign w_win      = rr_pick(ReqValid, r_prio);

  always_comb begin
    w_grant = 2'b00;
    if (w_open && (|ReqValid)) begin
      w_grant = {w_win, ~w_win};
    end
  end

  assign w_accept = |(ReqValid & w_grant);
  assign ReqReady = w_grant;

  assign RspValid    = (r_state == ST_RESP) ? {r_owner, ~r_owner} : 2'b00;
  assign RspResult   = r_result;
  assign RspZero     = r_zero;
  assign RspNegative = r_neg;

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_op    (r_op),
    .i_src_a (r_src_a),
    .i_src_b (r_src_b),
    .o_result(w_alu_result),
    .o_zero  (w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b0;
      r_prio   <= 1'b0;
      r_op     <= '0;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= ReqOp[w_win];
        r_src_a <= ReqSrcA[w_win];
        r_src_b <= ReqSrcB[w_win];
        r_owner <= w_win;
        r_prio  <= ~w_win;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state  <= ST_RESP;
          r_result <= w_alu_result;
          r_zero   <= w_alu_zero;
          r_neg    <= w_alu_result[DATA_WIDTH-1];
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_state <= w_accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  logic [1:0][CNT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ReqValid[i] && w_grant[i] && (r_grant_cnt[i] != {CNT_W{1'b1}})) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign GrantCount = r_grant_cnt;
`else
  assign GrantCount = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Drives and samples on the falling edge; DUT state changes on the rising one.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][3:0]     req_op;
  logic [1:0][DW-1:0]  req_a;
  logic [1:0][DW-1:0]  req_b;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DW-1:0]       rsp_result;
  logic                rsp_zero;
  logic                rsp_neg;
  logic [1:0][15:0]    grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ReqValid   (req_valid),
    .ReqReady   (req_ready),
    .ReqOp      (req_op),
    .ReqSrcA    (req_a),
    .ReqSrcB    (req_b),
    .RspValid   (rsp_valid),
    .RspReady   (rsp_ready),
    .RspResult  (rsp_result),
    .RspZero    (rsp_zero),
    .RspNegative(rsp_neg),
    .GrantCount (grant_cnt)
  );

  task automatic idle_inputs();
    req_valid = '0;
    rsp_ready = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hs: got %b want 0000", {req_ready, rsp_valid});
    end
    n_checks++;
    if ({rsp_result, rsp_zero, rsp_neg} !== {DW'(0), 2'b00}) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h/%b/%b want 0/0/0", rsp_result, rsp_zero, rsp_neg);
    end
    n_checks++;
    if (grant_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h want 0", grant_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    req_valid = 2'b01;
    req_op[0] = OP_ADD;
    req_a[0]  = 32'd5;
    req_b[0]  = 32'd7;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL add_ready: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL add_exec: got %b want 0000", {rsp_valid, req_ready});
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_zero} !== {2'b01, 32'd12, 1'b0}) begin
      n_fail++;
      $display("FAIL add_rsp: got %b %h %b want 01 0000000c 0", rsp_valid, rsp_result, rsp_zero);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL add_done: got %b want 00", rsp_valid);
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_both_valid();
    pulse_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_op[0] = OP_SUB;
    req_a[0]  = 32'd3;
    req_b[0]  = 32'd3;
    req_op[1] = OP_SLT;
    req_a[1]  = 32'hFFFF_FFFF;
    req_b[1]  = 32'd1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL both_first: got %b want 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_zero, req_ready} !== {2'b01, 32'd0, 1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL both_rsp0: got %b %h %b %b want 01 0 1 10",
               rsp_valid, rsp_result, rsp_zero, req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_zero} !== {2'b10, 32'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL both_rsp1: got %b %h %b want 10 1 0", rsp_valid, rsp_result, rsp_zero);
    end
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_alternate();
    logic [1:0]    exp_v;
    logic [DW-1:0] exp_r;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_op    = {OP_ADD, OP_ADD};
    req_a[0]  = 32'd1;
    req_b[0]  = 32'd1;
    req_a[1]  = 32'd10;
    req_b[1]  = 32'd20;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL alt_start: got %b want 01", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      exp_v = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (k % 2 == 0) ? 32'd2 : 32'd30;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready} !== 4'b0000) begin
        n_fail++;
        $display("FAIL alt_exec%0d: got %b want 0000", k, {rsp_valid, req_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_result, req_ready} !== {exp_v, exp_r, ~exp_v}) begin
        n_fail++;
        $display("FAIL alt_rsp%0d: got %b %h %b want %b %h %b",
                 k, rsp_valid, rsp_result, req_ready, exp_v, exp_r, ~exp_v);
      end
    end
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL alt_end: got %b want 00", rsp_valid);
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_ops();
    logic [3:0]    ops [12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                4'd9, 4'd1, 4'd0, 4'hA, 4'hF, 4'd8};
    logic [DW-1:0] va  [12] = '{32'hF0F0, 32'hF0F0, 32'hFF, 32'd1,
                                32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0,
                                32'hFFFF_FFFF, 32'd5, 32'd9, 32'd5};
    logic [DW-1:0] vb  [12] = '{32'hFF00, 32'h0F0F, 32'h0F, 32'd31, 32'd31,
                                32'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd5,
                                32'd3, 32'hFFFF_FFFD};
    logic [DW-1:0] ve  [12] = '{32'hF000, 32'hFFFF, 32'hF0, 32'h8000_0000,
                                32'd1, 32'hF800_0000, 32'd1, 32'hFFFF_FFFF,
                                32'd0, 32'd0, 32'd0, 32'd0};
    logic [DW-1:0] exp_r;
    rsp_ready = 2'b01;
    for (int i = 0; i < 12; i++) begin
      exp_r     = ve[i];
      req_valid = 2'b01;
      req_op[0] = ops[i];
      req_a[0]  = va[i];
      req_b[0]  = vb[i];
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_zero, rsp_neg} !==
          {2'b01, exp_r, exp_r == 32'd0, exp_r[DW-1]}) begin
        n_fail++;
        $display("FAIL op%0d: got %b %h z%b n%b want 01 %h z%b n%b", i,
                 rsp_valid, rsp_result, rsp_zero, rsp_neg,
                 exp_r, exp_r == 32'd0, exp_r[DW-1]);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01;
    req_op[0] = OP_ADD;
    req_a[0]  = 32'h7FFF_FFFF;
    req_b[0]  = 32'd1;
    req_op[1] = OP_OR;
    req_a[1]  = 32'd3;
    req_b[1]  = 32'd4;
    @(negedge clk);
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({rsp_valid, rsp_result, rsp_neg, rsp_zero, req_ready} !==
          {2'b01, 32'h8000_0000, 1'b1, 1'b0, 2'b00}) begin
        n_fail++;
        $display("FAIL hold%0d: got %b %h n%b z%b rdy %b want 01 80000000 n1 z0 rdy 00",
                 c, rsp_valid, rsp_result, rsp_neg, rsp_zero, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_release: got %b want 00", rsp_valid);
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_exec();
    req_valid = 2'b10;
    req_op[1] = OP_ADD;
    req_a[1]  = 32'd1;
    req_b[1]  = 32'd2;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, grant_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_exec: got %b %b %h %b %b %h want all 0",
               req_ready, rsp_valid, rsp_result, rsp_zero, rsp_neg, grant_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_norsp%0d: got %b want 00", c, rsp_valid);
      end
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_stats();
    logic [15:0] exp1;
`ifdef ALU_ARBITER_STATS_EN
    exp1 = 16'd3;
`else
    exp1 = 16'd0;
`endif
    pulse_reset();
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b10;
      req_op[1] = OP_XOR;
      req_a[1]  = 32'(i);
      req_b[1]  = 32'hFF;
      #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
        n_fail++;
        $display("FAIL stats_ready%0d: got %b want 10", i, req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (grant_cnt !== {exp1, 16'd0}) begin
      n_fail++;
      $display("FAIL stats_cnt: got %h want %h", grant_cnt, {exp1, 16'd0});
    end
    rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_both_valid();
    test_alternate();
    test_ops();
    test_backpressure();
    test_reset_mid_exec();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
